// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle radix-2 restoring divider. Divides a (WX+WY)-bit
//             unsigned dividend Z by a WY-bit unsigned divisor Y, producing a
//             WX-bit quotient X and WY-bit remainder R with Z = X*Y + R.
//             One division in flight; valid/ready handshake on both sides.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready / Z / Y        operand handshake
//             out_valid / out_ready / X / R / err result handshake
//             err = divide-by-zero or quotient overflow (X all ones, R = 0)
//  Options  : SEQDIV_ZERO_SKIP_EN - when defined, a non-error Z==0 bypasses
//             the iterative steps and completes with latency 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WX = 8,
    parameter int WY = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WX+WY-1:0] Z,
    input  logic [WY-1:0]    Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WX-1:0]    X,
    output logic [WY-1:0]    R,
    output logic             err
);

    localparam int            CW     = (WX > 1) ? $clog2(WX) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [WY-1:0]   r_y;
    logic [WY-1:0]   r_p;          // partial remainder, always < divisor
    logic [WX-1:0]   r_zlo;        // remaining dividend bits, MSB consumed first
    logic [WX-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_err_pend;   // error detected at acceptance
    logic            r_zero_pend;  // zero-dividend shortcut detected at acceptance
    logic            r_in_ready;
    logic            r_out_valid;
    logic [WX-1:0]   r_x;
    logic [WY-1:0]   r_r;
    logic            r_err;

    logic [WY:0]     w_t;
    logic            w_ge;
    logic [WY-1:0]   w_p_next;
    logic [WX-1:0]   w_q_next;
    logic            w_in_err;
    logic            w_in_zero;

    // One restoring step: shift in the next dividend bit and try to subtract.
    assign w_t      = {r_p, r_zlo[WX-1]};
    assign w_ge     = (w_t >= {1'b0, r_y});
    // When T >= Y the true difference is < Y, so the low WY bits of a modular
    // subtraction are exact and the carry-out bit need not be kept.
    assign w_p_next = w_ge ? (w_t[WY-1:0] - r_y) : w_t[WY-1:0];
    assign w_q_next = (r_q << 1) | WX'(w_ge);

    // Quotient overflows WX bits exactly when the upper dividend half >= Y.
    assign w_in_err = (Y == '0) || (Z[WX+WY-1:WX] >= Y);

`ifdef SEQDIV_ZERO_SKIP_EN
    assign w_in_zero = (Z == '0);
`else
    assign w_in_zero = 1'b0;
`endif

    // The error/zero decision is captured at acceptance and resolved in the
    // first RUN cycle, which gives those paths a fixed latency of one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_p         <= '0;
            r_zlo       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_err_pend  <= 1'b0;
            r_zero_pend <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_r         <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_y         <= Y;
                        r_p         <= Z[WX+WY-1:WX];
                        r_zlo       <= Z[WX-1:0];
                        r_q         <= '0;
                        r_cnt       <= '0;
                        r_err_pend  <= w_in_err;
                        r_zero_pend <= w_in_zero;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (r_err_pend) begin
                        r_x         <= '1;
                        r_r         <= '0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_zero_pend) begin
                        r_x         <= '0;
                        r_r         <= '0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_p   <= w_p_next;
                        r_q   <= w_q_next;
                        r_zlo <= r_zlo << 1;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == C_LAST) begin
                            r_x         <= w_q_next;
                            r_r         <= w_p_next;
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign X         = r_x;
    assign R         = r_r;
    assign err       = r_err;

endmodule

`default_nettype wire
